// File: rtl/tts_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tts_pkg
//  Description : Shared definitions for the truth-table sweeper: FSM state
//                encoding, state enum and legal parameter ranges.
//  Revision    : 1.0 - initial release
// ============================================================================
package tts_pkg;

    // FSM state encoding (2-bit)
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] APPLY  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_APPLY  = APPLY,
        ST_SAMPLE = SAMPLE,
        ST_DONE   = DONE
    } tts_state_t;

    // Legal parameter ranges
    localparam int c_N_IN_MIN    = 1;
    localparam int c_N_IN_MAX    = 8;
    localparam int c_SETTLE_MIN  = 1;
    localparam int c_SETTLE_MAX  = 255;

    // Settle counter width covers c_SETTLE_MAX
    localparam int c_SETTLE_CNT_W = 8;

endpackage : tts_pkg
`default_nettype wire

// File: rtl/tts_settle_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tts_settle_counter
//  Description : Counts the cycles a vector has been held. tc_o is high during
//                the SETTLE_CYCLES-th enabled cycle, so a consumer that leaves
//                its hold state on tc_o holds for exactly SETTLE_CYCLES cycles.
//  Ports       : clk      - clock
//                rst_n    - asynchronous active-low reset
//                clear_i  - synchronous clear to zero (priority over en_i)
//                en_i     - count enable
//                tc_o     - terminal count (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module tts_settle_counter
    import tts_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [c_SETTLE_CNT_W-1:0] c_TC_VAL = c_SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    logic [c_SETTLE_CNT_W-1:0] count_q;
    logic [c_SETTLE_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + c_SETTLE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = en_i && (count_q == c_TC_VAL);

endmodule : tts_settle_counter
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweeper
//  Description : Drives every input vector 0..2**N_IN-1 into an external
//                combinational DUT, holds each for SETTLE_CYCLES cycles, then
//                compares the DUT output with the captured truth table and
//                keeps a mismatch count and the first failing vector.
//  Config      : TTS_STOP_ON_FAIL_EN - when defined, the first mismatch ends
//                the sweep with vec_out_o frozen at the failing vector.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                start_i               - sweep request (IDLE/DONE only)
//                tt_expected_i         - expected output table, bit k = vec k
//                dut_out_i             - observed DUT output
//                vec_out_o             - vector driven to the DUT
//                busy_o / done_o       - sweep running / finished
//                pass_o                - done and no mismatches
//                err_count_o           - mismatch count
//                first_fail_valid_o    - a mismatch has been recorded
//                first_fail_vec_o      - vector of the first mismatch
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [(2**N_IN)-1:0]   tt_expected_i,
    input  logic                   dut_out_i,
    output logic [N_IN-1:0]        vec_out_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic [N_IN:0]          err_count_o,
    output logic                   first_fail_valid_o,
    output logic [N_IN-1:0]        first_fail_vec_o
);

    localparam int              c_NVEC     = 2**N_IN;
    localparam logic [N_IN-1:0] c_LAST_VEC = {N_IN{1'b1}};

    tts_state_t          state_q, state_d;
    logic [c_NVEC-1:0]   tt_q, tt_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic [N_IN:0]       err_q, err_d;
    logic                ffv_q, ffv_d;
    logic [N_IN-1:0]     ffvec_q, ffvec_d;

    logic                cnt_clear;
    logic                cnt_en;
    logic                cnt_tc;
    logic                mismatch;

    tts_settle_counter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .tc_o    (cnt_tc)
    );

    assign mismatch = (dut_out_i != tt_q[vec_q]);

    always_comb begin
        state_d   = state_q;
        tt_d      = tt_q;
        vec_d     = vec_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvec_d   = ffvec_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d   = ST_APPLY;
                    tt_d      = tt_expected_i;
                    vec_d     = '0;
                    err_d     = '0;
                    ffv_d     = 1'b0;
                    ffvec_d   = '0;
                    cnt_clear = 1'b1;
                end
            end

            ST_APPLY: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                // Counter cleared here so the next vector starts from zero.
                cnt_clear = 1'b1;
                if (mismatch) begin
                    // At most 2**N_IN increments per sweep, which N_IN+1 bits hold.
                    err_d = err_q + (N_IN+1)'(1);
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec_q;
                    end
                end
`ifdef TTS_STOP_ON_FAIL_EN
                if (mismatch || (vec_q == c_LAST_VEC)) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    state_d = ST_APPLY;
                end
`else
                if (vec_q == c_LAST_VEC) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    state_d = ST_APPLY;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tt_q    <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else begin
            state_q <= state_d;
            tt_q    <= tt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
        end
    end

    assign vec_out_o          = vec_q;
    assign busy_o             = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
    assign done_o             = (state_q == ST_DONE);
    assign pass_o             = (state_q == ST_DONE) && (err_q == '0);
    assign err_count_o        = err_q;
    assign first_fail_valid_o = ffv_q;
    assign first_fail_vec_o   = ffvec_q;

endmodule : truth_table_sweeper
`default_nettype wire

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter N_IN, default 2: number of DUT inputs driven; legal range 1..8.
REQ-002 Parameter SETTLE_CYCLES, default 4: cycles each vector is held before sampling; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-005 start  input  1  one-cycle sweep request; honoured only in IDLE or DONE.
REQ-006 tt_expected  input  2**N_IN  expected DUT output; bit k is the output for input vector k; captured at start.
REQ-007 dut_out  input  1  observed DUT output.
REQ-008 vec_out  output  N_IN  input vector driven to the DUT.
REQ-009 busy  output  1  high in APPLY and SAMPLE.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  valid while done; high when err_count == 0.
REQ-012 err_count  output  N_IN+1  mismatch count for the current or last sweep.
REQ-013 first_fail_valid  output  1  high once any mismatch has been recorded in the sweep.
REQ-014 first_fail_vec  output  N_IN  vector of the first mismatch; valid when first_fail_valid is high.

Function
REQ-015 FSM states: IDLE, APPLY, SAMPLE, DONE.
REQ-016 IDLE/DONE + start -> APPLY; tt_expected registered; vec_out=0, err_count=0, first_fail_valid=0, settle counter=0.
REQ-017 APPLY: settle counter increments each cycle; after exactly SETTLE_CYCLES cycles in APPLY -> SAMPLE.
REQ-018 SAMPLE, one cycle: if dut_out != tt_exp_reg[vec_out], err_count += 1; first mismatch loads first_fail_vec and sets first_fail_valid.
REQ-019 SAMPLE, vec_out != 2**N_IN-1: vec_out += 1, counter cleared -> APPLY; last vector -> DONE.
REQ-020 Each vector occupies SETTLE_CYCLES+1 cycles; done rises (SETTLE_CYCLES+1)*2**N_IN + 1 cycles after the start edge.
REQ-021 DONE holds vec_out, err_count, first_fail_* and pass until the next start or reset.
REQ-022 start while busy is ignored; no effect on state, counters or registered table.
REQ-023 tt_expected changes after start do not affect the running sweep.
REQ-024 err_count cannot overflow (max 2**N_IN fits N_IN+1 bits); no saturation logic.
REQ-025 pass = done & (err_count == 0); low in all other states.

Reset
REQ-026 rst_n low, at any time including mid-sweep: state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, settle counter=0, table register=0.
REQ-027 First start is accepted on the first clock edge after rst_n deassertion.

Configuration
REQ-028 Macro TTS_STOP_ON_FAIL_EN defined: a SAMPLE mismatch goes directly to DONE with vec_out frozen at the failing vector; err_count is therefore 0 or 1.
REQ-029 Macro TTS_STOP_ON_FAIL_EN undefined: the sweep always covers all 2**N_IN vectors, per REQ-019.

Structure
REQ-030 Package tts_pkg holds the FSM state encoding (2-bit localparams IDLE=0, APPLY=1, SAMPLE=2, DONE=3) and N_IN/SETTLE_CYCLES legal-range constants.
REQ-031 Sub-module tts_settle_counter (load/clear, enable, terminal-count output at SETTLE_CYCLES) is instantiated once; all other logic lives in truth_table_sweeper.

Verification
REQ-032 AND DUT, N_IN=2, SETTLE_CYCLES=4, tt_expected=4'b1000 -> vec_out steps 0,1,2,3; done at cycle 21 after start; pass=1, err_count=0, first_fail_valid=0.
REQ-033 OR DUT, tt_expected=4'b1000 -> err_count=2, first_fail_vec=2'b01, first_fail_valid=1, pass=0.
REQ-034 rst_n pulsed low during APPLY of vector 2 -> all outputs reach REQ-026 values with no clock edge; a new start then produces a full, correct sweep.
REQ-035 start re-pulsed during SAMPLE of vector 1 -> ignored; sweep completes at the same cycle as REQ-032.
REQ-036 TTS_STOP_ON_FAIL_EN defined, OR DUT, tt_expected=4'b1000 -> DONE after vector 1 sample (cycle 11); vec_out=1, err_count=1, pass=0.
REQ-037 N_IN=3, SETTLE_CYCLES=1, XOR3 DUT, tt_expected=8'b10010110 -> done at cycle 17; pass=1.
